pwm_multi_channel: RTL and testbench

//   Multi-channel PWM peripheral on the Wishbone bus. It generalises the single 8-bit channel block.
//   - CHANNELS outputs share one prescaler and one WIDTH-bit period counter.
//   - Each channel has a double-buffered duty register, so updates are glitch-free.
//   - Per-channel enables are applied on period boundaries.
//   - Sits beside the other Wishbone peripherals and drives LEDs, motors and servos.

---
 rtl/pwm_multi_channel.sv | 148 ++++++++++++++
 tb/tb_pwm_multi_channel.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_channel.sv
// Multi-channel Wishbone PWM: shared prescaler and counter, per-channel
// double-buffered duty, enables applied at period wrap.
// Ports: clk, rst (async, active-high); Wishbone slave wb_stb, wb_we,
//   wb_adr[4:0], wb_dat_i[15:0], wb_dat_o[15:0], wb_ack; pwm[CHANNELS-1:0].
// Map: 0..CHANNELS-1 duty pending, 16 enable, 17 polarity, 18 cnt (ro).
// Optional macro PWM_POLARITY_EN adds the polarity register at adr 17.
module pwm_multi_channel #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_stb,
  input  logic                wb_we,
  input  logic [4:0]          wb_adr,
  input  logic [15:0]         wb_dat_i,
  output logic [15:0]         wb_dat_o,
  output logic                wb_ack,
  output logic [CHANNELS-1:0] pwm
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CMAX = {WIDTH{1'b1}};

  logic [PW-1:0]       presc_q, presc_d;
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    pend_q [CHANNELS];
  logic [WIDTH-1:0]    pend_d [CHANNELS];
  logic [WIDTH-1:0]    act_q [CHANNELS];
  logic [WIDTH-1:0]    act_d [CHANNELS];
  logic [CHANNELS-1:0] en_q, en_d;
  logic [CHANNELS-1:0] act_en_q, act_en_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                ack_q, ack_d;
  logic [15:0]         dat_q, dat_d;
  logic [15:0]         rdata;
  logic                tick, wrap, acc, wr;
  logic                unused_bits;

`ifdef PWM_POLARITY_EN
  logic [CHANNELS-1:0] pol_q, pol_d;
  logic [CHANNELS-1:0] act_pol_q, act_pol_d;
`endif

  assign unused_bits = ^wb_dat_i;

  assign tick = (presc_q == PMAX);
  assign wrap = tick & (cnt_q == CMAX);
  // A bus access is taken on the edge that raises ack.
  assign acc  = wb_stb & ~ack_q;
  assign wr   = acc & wb_we;

  always_comb begin
    rdata = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (wb_adr == 5'(i)) rdata = 16'(pend_q[i]);
    if (wb_adr == 5'd16) rdata = 16'(en_q);
`ifdef PWM_POLARITY_EN
    if (wb_adr == 5'd17) rdata = 16'(pol_q);
`endif
    if (wb_adr == 5'd18) rdata = 16'(cnt_q);
  end

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    cnt_d   = tick ? cnt_q + 1'b1 : cnt_q;
    ack_d   = acc;
    dat_d   = (acc & ~wb_we) ? rdata : '0;
    en_d    = en_q;
    if (wr && wb_adr == 5'd16) en_d = wb_dat_i[CHANNELS-1:0];
    for (int i = 0; i < CHANNELS; i++) begin
      pend_d[i] = pend_q[i];
      if (wr && wb_adr == 5'(i)) pend_d[i] = wb_dat_i[WIDTH-1:0];
    end
    // Transfer uses the pre-edge pending values, so a write
    // landing on the wrap edge waits for the next period.
    act_d    = act_q;
    act_en_d = act_en_q;
    if (wrap) begin
      act_d    = pend_q;
      act_en_d = en_q;
    end
  end

`ifdef PWM_POLARITY_EN
  always_comb begin
    pol_d = pol_q;
    if (wr && wb_adr == 5'd17) pol_d = wb_dat_i[CHANNELS-1:0];
    act_pol_d = wrap ? pol_q : act_pol_q;
  end
`endif

  // Live enable gates the boundary-latched one: clearing a bit
  // silences the channel next clk, setting waits for wrap.
  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < CHANNELS; i++)
      pwm_d[i] = act_en_q[i] & en_q[i] & (act_q[i] > cnt_q);
`ifdef PWM_POLARITY_EN
    pwm_d = pwm_d ^ act_pol_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q  <= '0;
      cnt_q    <= '0;
      en_q     <= '0;
      act_en_q <= '0;
      pwm_q    <= '0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        pend_q[i] <= '0;
        act_q[i]  <= '0;
      end
    end else begin
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      act_en_q <= act_en_d;
      pwm_q    <= pwm_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      pend_q   <= pend_d;
      act_q    <= act_d;
    end
  end

`ifdef PWM_POLARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pol_q     <= '0;
      act_pol_q <= '0;
    end else begin
      pol_q     <= pol_d;
      act_pol_q <= act_pol_d;
    end
  end
`endif

  assign pwm      = pwm_q;
  assign wb_ack   = ack_q;
  assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Bench for pwm_multi_channel: two instances (PRESCALE 1 and 3)
// checked every cycle against a time-based model plus literals.
module tb_pwm_multi_channel;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_stb = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_adr = '0;
  logic [15:0] wb_dat_i = '0;
  logic [15:0] dat1, dat3;
  logic        ack1, ack3;
  logic [3:0]  pwm1, pwm3;

  int errors = 0;
  int checks = 0;

  pwm_multi_channel #(.CHANNELS(4), .WIDTH(8), .PRESCALE(1)) u1 (
    .clk(clk), .rst(rst), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(dat1),
    .wb_ack(ack1), .pwm(pwm1));

  pwm_multi_channel #(.CHANNELS(4), .WIDTH(8), .PRESCALE(3)) u3 (
    .clk(clk), .rst(rst), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(dat3),
    .wb_ack(ack3), .pwm(pwm3));

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: time since reset (edges seen) gives cnt = (n/P) mod 256,
  // period boundary is every 256*P edges.
  int unsigned mn [2] = '{0, 0};
  int unsigned pr [2] = '{1, 3};
  logic [7:0]  m_pend [2][4];
  logic [7:0]  m_act  [2][4];
  logic [3:0]  m_en [2], m_aen [2], m_pol [2], m_apol [2];
  logic [3:0]  e_pwm [2];
  logic        e_ack [2];
  logic [15:0] e_dat [2];

  task automatic m_reset(input int k);
    mn[k] = 0;
    for (int c = 0; c < 4; c++) begin
      m_pend[k][c] = 0;
      m_act[k][c] = 0;
    end
    m_en[k] = 0; m_aen[k] = 0; m_pol[k] = 0; m_apol[k] = 0;
    e_pwm[k] = 0; e_ack[k] = 0; e_dat[k] = 0;
  endtask

  function automatic logic [15:0] m_read(input int k,
                                         input logic [4:0] a);
    if (a < 5'd4) return {8'h0, m_pend[k][a[1:0]]};
    if (a == 5'd16) return {12'h0, m_en[k]};
`ifdef PWM_POLARITY_EN
    if (a == 5'd17) return {12'h0, m_pol[k]};
`endif
    if (a == 5'd18) return 16'((mn[k] / pr[k]) % 256);
    return 16'h0;
  endfunction

  task automatic m_step(input int k);
    int cnt;
    logic [3:0] o;
    logic acc;
    cnt = int'((mn[k] / pr[k]) % 256);
    for (int c = 0; c < 4; c++)
      o[c] = m_aen[k][c] & m_en[k][c] & (int'(m_act[k][c]) > cnt);
`ifdef PWM_POLARITY_EN
    o = o ^ m_apol[k];
`endif
    e_pwm[k] = o;
    acc = wb_stb & ~e_ack[k];
    e_dat[k] = (acc & ~wb_we) ? m_read(k, wb_adr) : 16'h0;
    e_ack[k] = acc;
    if ((mn[k] + 1) % (256 * pr[k]) == 0) begin
      m_act[k] = m_pend[k];
      m_aen[k] = m_en[k];
      m_apol[k] = m_pol[k];
    end
    if (acc & wb_we) begin
      if (wb_adr < 5'd4) m_pend[k][wb_adr[1:0]] = wb_dat_i[7:0];
      if (wb_adr == 5'd16) m_en[k] = wb_dat_i[3:0];
`ifdef PWM_POLARITY_EN
      if (wb_adr == 5'd17) m_pol[k] = wb_dat_i[3:0];
`endif
    end
    mn[k]++;
  endtask

  initial begin
    m_reset(0);
    m_reset(1);
    forever begin
      @(posedge clk or posedge rst);
      for (int k = 0; k < 2; k++)
        if (rst) m_reset(k);
        else m_step(k);
    end
  end

  always @(negedge clk) begin
    check("pwm_p1", {28'h0, pwm1}, {28'h0, e_pwm[0]});
    check("ack_p1", {31'h0, ack1}, {31'h0, e_ack[0]});
    check("dat_p1", {16'h0, dat1}, {16'h0, e_dat[0]});
    check("pwm_p3", {28'h0, pwm3}, {28'h0, e_pwm[1]});
    check("ack_p3", {31'h0, ack3}, {31'h0, e_ack[1]});
    check("dat_p3", {16'h0, dat3}, {16'h0, e_dat[1]});
  end

  // Called on a negedge with ack low; returns on a negedge.
  task automatic bus(input logic we, input logic [4:0] adr,
                     input logic [15:0] d,
                     output logic [15:0] r1, output logic [15:0] r3);
    wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = d;
    @(negedge clk);
    r1 = dat1; r3 = dat3;
    check("bus_ack", {30'h0, ack1, ack3}, 32'h3);
    wb_stb = 1'b0; wb_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] adr, input logic [15:0] d);
    logic [15:0] a, b;
    bus(1'b1, adr, d, a, b);
  endtask

  task automatic count_high(input int k, input int ch, input int n,
                            output int h);
    h = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      h += int'(k == 0 ? pwm1[ch] : pwm3[ch]);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] r1, r3;
    logic [3:0] pat;
    int h, i;
    logic [4:0] adr_tab [8];
    adr_tab = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd16, 5'd17, 5'd18, 5'd25};

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pwm", {24'h0, pwm1, pwm3}, 32'h0);
    check("rst_ack", {30'h0, ack1, ack3}, 32'h0);
    check("rst_dat", {dat1, dat3}, 32'h0);
    rst = 1'b0;

    bus(1'b0, 5'd18, 16'h0, r1, r3);
    check("cnt_after_rst", {r1, r3}, 32'h0);

    wr(5'd0, 16'd64);
    wr(5'd1, 16'd255);
    wr(5'd16, 16'h3);
    repeat (800) @(negedge clk);
    count_high(0, 0, 256, h);
    check("duty64_high", h, 64);
    count_high(1, 1, 768, h);
    check("p3_duty255_high", h, 765);

    wr(5'd0, 16'd200);
    repeat (300) @(negedge clk);
    count_high(0, 0, 256, h);
    check("shadow_duty200", h, 200);

    for (i = 0; i < 300 && (mn[0] % 256) != 255; i++) @(negedge clk);
    check("align_wrap", {31'h0, (mn[0] % 256) == 255}, 32'h1);
    wr(5'd0, 16'd32);
    count_high(0, 0, 256, h);
    check("wrap_write_deferred", h, 200);
    count_high(0, 0, 256, h);
    check("wrap_write_applied", h, 32);

    wr(5'd0, 16'd0);
    repeat (300) @(negedge clk);
    count_high(0, 0, 256, h);
    check("duty0_low", h, 0);

    for (int n = 0; n < 30; n++) begin
      bus(1'($urandom_range(0, 1)), adr_tab[$urandom_range(0, 7)],
          16'($urandom), r1, r3);
      repeat ($urandom_range(0, 250)) @(negedge clk);
    end

    wr(5'd2, 16'h12A5);
    wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 5'd2;
    pat = {3'b0, ack1};
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      pat = {pat[2:0], ack1};
      if (ack1) check("b2b_read", {16'h0, dat1}, 32'h00A5);
    end
    wb_stb = 1'b0;
    check("b2b_ack_pat", {28'h0, pat}, 32'h5);
    @(negedge clk);

    bus(1'b0, 5'd25, 16'h0, r1, r3);
    check("unmapped_read", {r1, r3}, 32'h0);

    wr(5'd0, 16'd200);
    wr(5'd16, 16'h1);
    repeat (600) @(negedge clk);
    wr(5'd16, 16'h0);
    check("disable_low", {31'h0, pwm1[0]}, 32'h0);
    wr(5'd16, 16'h1);
    repeat (600) @(negedge clk);
    for (i = 0; i < 300 && pwm1[0] !== 1'b1; i++) @(negedge clk);
    check("pre_rst_high", {31'h0, pwm1[0]}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pwm", {24'h0, pwm1, pwm3}, 32'h0);
    check("async_rst_ack", {30'h0, ack1, ack3}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus(1'b0, 5'd18, 16'h0, r1, r3);
    check("cnt_after_async", {r1, r3}, 32'h0);

`ifdef PWM_POLARITY_EN
    wr(5'd17, 16'h1);
    wr(5'd0, 16'd64);
    wr(5'd16, 16'h1);
    repeat (600) @(negedge clk);
    count_high(0, 0, 256, h);
    check("pol_high", h, 192);
    wr(5'd16, 16'h0);
    check("pol_idle_high", {31'h0, pwm1[0]}, 32'h1);
`else
    wr(5'd17, 16'hF);
    bus(1'b0, 5'd17, 16'h0, r1, r3);
    check("pol_absent", {r1, r3}, 32'h0);
`endif

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
